// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared defaults and trigger-level encoding for the UART receive FIFO
package uart_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ERR_W  = 3;
    localparam int DEF_DEPTH  = 16;

    localparam logic [1:0] TRIG_1  = 2'b00;
    localparam logic [1:0] TRIG_Q  = 2'b01;
    localparam logic [1:0] TRIG_H  = 2'b10;
    localparam logic [1:0] TRIG_NF = 2'b11;

    // Occupancy at which the receive interrupt level is reached.
    function automatic int trig_threshold(input logic [1:0] sel, input int depth);
        case (sel)
            TRIG_Q:  return depth / 4;
            TRIG_H:  return depth / 2;
            TRIG_NF: return depth - 2;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - FIFO storage: one synchronous write port, one asynchronous read port
module uart_fifo_ram #(
    parameter int WIDTH  = 11,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rfifo_gen.sv
// rtl/uart_rfifo_gen.sv - parametrised UART receive FIFO with status tracking and trigger level
module uart_rfifo_gen
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ERR_W  = DEF_ERR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    wb_rst_i,
    input  logic                    fifo_reset,
    input  logic                    reset_status,
    input  logic                    push,
    input  logic [DATA_W+ERR_W-1:0] data_in,
    input  logic                    pop,
    input  logic [1:0]              trig_level,
    output logic [DATA_W+ERR_W-1:0] data_out,
    output logic [CNT_W-1:0]        count,
    output logic                    empty,
    output logic                    full,
    output logic                    overrun,
    output logic                    error_bit,
    output logic                    level_hit
);

    localparam int W = DATA_W + ERR_W;

    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] bottom;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] level;
    logic [W-1:0]     head;
    logic             pop_eff;
    logic             push_eff;
    logic             inc;
    logic             dec;
    logic             wr_en;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);
    assign wr_en    = push_eff & ~fifo_reset;

    // Error count tracks stored entries with nonzero status, so no wide OR over memory.
    assign inc = push_eff & (|data_in[ERR_W-1:0]);
    assign dec = pop_eff & (|head[ERR_W-1:0]);

    uart_fifo_ram #(
        .WIDTH  (W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (top),
        .wdata (data_in),
        .raddr (bottom),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            top     <= '0;
            bottom  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else if (fifo_reset) begin
            top     <= '0;
            bottom  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (push_eff) top <= top + PTR_W'(1);
            if (pop_eff) bottom <= bottom + PTR_W'(1);
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            case ({inc, dec})
                2'b10:   err_cnt <= err_cnt + CNT_W'(1);
                2'b01:   err_cnt <= err_cnt - CNT_W'(1);
                default: err_cnt <= err_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            overrun <= 1'b0;
        end else if (fifo_reset || reset_status) begin
            overrun <= 1'b0;
        end else if (push && full && !pop_eff) begin
            overrun <= 1'b1;
        end
    end

    always_comb begin
        level = CNT_W'(trig_threshold(trig_level, DEPTH));
    end

    assign data_out  = empty ? '0 : head;
    assign error_bit = (err_cnt != '0);
    assign level_hit = (count >= level);

endmodule

// File: tb/tb_uart_rfifo_gen.sv
// tb/tb_uart_rfifo_gen.sv - scoreboard bench for uart_rfifo_gen
module tb_uart_rfifo_gen;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        fifo_reset = 1'b0;
    logic        reset_status = 1'b0;
    logic        push = 1'b0;
    logic [10:0] data_in = '0;
    logic        pop = 1'b0;
    logic [1:0]  trig_level = 2'b00;
    logic [10:0] data_out;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overrun;
    logic        error_bit;
    logic        level_hit;

    int total = 0;
    int bad = 0;
    logic [10:0] exp_q[$];
    int trig_exp[4] = '{1, 4, 8, 14};

    uart_rfifo_gen dut (
        .clk          (clk),
        .wb_rst_i     (wb_rst_i),
        .fifo_reset   (fifo_reset),
        .reset_status (reset_status),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .trig_level   (trig_level),
        .data_out     (data_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overrun      (overrun),
        .error_bit    (error_bit),
        .level_hit    (level_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected entry.
    always @(negedge clk) begin
        if (wb_rst_i && pop && !empty && !fifo_reset) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_data: got %0h expected nothing queued", data_out);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %0h expected %0h at %0t", data_out, e, $time);
                end
            end
        end
    end

    task automatic drive(input logic p, input logic [10:0] d, input logic q,
                         input logic rs, input logic fr);
        bit pe, acc;
        pe  = q && (exp_q.size() != 0) && !fr;
        acc = p && !fr && ((exp_q.size() < 16) || pe);
        push = p; data_in = d; pop = q; reset_status = rs; fifo_reset = fr;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; reset_status = 1'b0; fifo_reset = 1'b0;
        if (fr) exp_q.delete();
        else if (acc) exp_q.push_back(d);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && !empty; n++) drive(0, '0, 1, 0, 0);
        chk("drain_empty", empty, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 wb_rst_i = 1'b1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_err", error_bit, 0);
        chk("rst_level", level_hit, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ovr", overrun, 0);

        // Fill
        for (int i = 0; i < 16; i++) drive(1, {8'(i), 3'b000}, 0, 0, 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);

        // Overrun handling
        drive(1, {8'hAA, 3'b000}, 0, 0, 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_count", count, 16);
        chk("ovr_head", data_out, {8'h00, 3'b000});
        drive(0, '0, 0, 1, 0);
        chk("ovr_clear", overrun, 0);
        drive(1, {8'hAA, 3'b000}, 0, 1, 0);
        chk("ovr_clear_wins", overrun, 0);
        chk("ovr_count2", count, 16);

        // Push + pop on full
        drive(1, {8'h55, 3'b000}, 1, 0, 0);
        chk("pp_full_count", count, 16);
        chk("pp_full_ovr", overrun, 0);
        for (int i = 0; i < 15; i++) drive(0, '0, 1, 0, 0);
        chk("pp_full_55", data_out, {8'h55, 3'b000});
        drive(0, '0, 1, 0, 0);
        chk("drained_empty", empty, 1);
        chk("drained_data", data_out, 0);

        // Push + pop on empty
        drive(1, {8'h3C, 3'b000}, 1, 0, 0);
        chk("pp_empty_count", count, 1);
        chk("pp_empty_data", data_out, {8'h3C, 3'b000});
        drain();

        // Error tracking
        drive(1, {8'h41, 3'b100}, 0, 0, 0);
        drive(1, {8'h42, 3'b000}, 0, 0, 0);
        drive(1, {8'h43, 3'b001}, 0, 0, 0);
        chk("err_set", error_bit, 1);
        drive(0, '0, 1, 0, 0);
        chk("err_pop1", error_bit, 1);
        drive(0, '0, 1, 0, 0);
        chk("err_pop2", error_bit, 1);
        drive(0, '0, 1, 0, 0);
        chk("err_pop3", error_bit, 0);
        chk("err_count", count, 0);

        // Trigger levels
        for (int t = 0; t < 4; t++) begin
            trig_level = 2'(t);
            for (int k = 0; k < 17 && !level_hit; k++)
                drive(1, {8'(8'h80 + t * 16 + k), 3'b000}, 0, 0, 0);
            chk("trig_rise", count, trig_exp[t]);
            chk("trig_hit", level_hit, 1);
            drive(0, '0, 1, 0, 0);
            chk("trig_fall", level_hit, 0);
            drain();
        end
        trig_level = 2'b00;

        // Asynchronous reset with 5 entries and overrun pending
        for (int i = 0; i < 16; i++) drive(1, {8'(8'hC0 + i), 3'b010}, 0, 0, 0);
        drive(1, {8'hEE, 3'b000}, 0, 0, 0);
        for (int i = 0; i < 11; i++) drive(0, '0, 1, 0, 0);
        chk("pre_rst_count", count, 5);
        chk("pre_rst_ovr", overrun, 1);
        chk("pre_rst_err", error_bit, 1);
        #3 wb_rst_i = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ovr", overrun, 0);
        chk("arst_err", error_bit, 0);
        chk("arst_data", data_out, 0);
        exp_q.delete();
        #2 wb_rst_i = 1'b1;
        drive(1, {8'h99, 3'b000}, 0, 0, 0);
        chk("arst_first_push", data_out, {8'h99, 3'b000});
        drain();

        // Synchronous flush
        for (int i = 0; i < 3; i++) drive(1, {8'(8'h10 + i), 3'b001}, 0, 0, 0);
        drive(1, {8'hBB, 3'b000}, 0, 0, 1);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_err", error_bit, 0);
        drive(1, {8'h77, 3'b000}, 0, 0, 0);
        chk("flush_next", data_out, {8'h77, 3'b000});
        chk("flush_next_cnt", count, 1);
        drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
